// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
//   Boot sequencer for the risc_v core. It streams a program from an external
//   loader into instruction memory over a valid/ready handshake while holding
//   the core in reset. After the last word it waits RST_HOLD cycles and then
//   releases the core. A new load may be started from RUN, which puts the
//   core back into reset.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_i            synchronous active-high reset
//   load_start_i     pulse: start a program load at word 0
//   load_valid_i     load_data_i / load_last_i valid this cycle
//   load_data_i      instruction word
//   load_last_i      final word of the program
//   load_ready_o     controller accepts a beat this cycle (high in LOAD)
//   imem_wr_en_o     imem write strobe, one cycle per accepted beat
//   imem_wr_addr_o   imem word address
//   imem_data_in_o   imem write data
//   core_rst_o       core reset, active-high
//   boot_done_o      high while the core runs a loaded program
//   word_count_o     words written in the current/last load (saturates at DEPTH)
//   err_overflow_o   sticky: imem filled before load_last was seen
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset; core held in reset, waiting for load_start
// LOAD  | accepting beats and writing them to imem
// HOLD  | last word written; core reset held for RST_HOLD cycles
// RUN   | core released; load_start begins a reload

module imem_boot_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int RST_HOLD = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [31:0]       load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              imem_wr_en_o,
    output logic [ADDR_W-1:0] imem_wr_addr_o,
    output logic [31:0]       imem_data_in_o,
    output logic              core_rst_o,
    output logic              boot_done_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              err_overflow_o
);

    localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
    localparam logic [ADDR_W:0]   WC_MAX    = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     word_count_q;
    logic                err_overflow_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [31:0]         wr_data_q;

    logic accept;
    logic at_top;
    logic start_load;
    logic enter_hold;

    assign accept     = load_valid_i & (state_q == S_LOAD);
    assign at_top     = (addr_q == {ADDR_W{1'b1}});
    // load_start only matters where a load may begin; LOAD and HOLD ignore it
    assign start_load = load_start_i & ((state_q == S_IDLE) | (state_q == S_RUN));
    // a full imem ends the load just like load_last, so addr never wraps
    assign enter_hold = accept & (load_last_i | at_top);

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_load) state_d = S_LOAD;
            S_LOAD:  if (enter_hold) state_d = S_HOLD;
            S_HOLD:  if (hold_cnt_q == HOLD_W'(1)) state_d = S_RUN;
            S_RUN:   if (start_load) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        load_ready_o = (state_q == S_LOAD);
        core_rst_o   = (state_q != S_RUN);
        boot_done_o  = (state_q == S_RUN);
    end

    // datapath: address/count bookkeeping, hold timer, registered imem port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q         <= '0;
            word_count_q   <= '0;
            err_overflow_q <= 1'b0;
            hold_cnt_q     <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else begin
            wr_en_q <= accept;
            if (start_load) begin
                addr_q         <= '0;
                word_count_q   <= '0;
                err_overflow_q <= 1'b0;
            end
            if (accept) begin
                wr_addr_q <= addr_q;
                wr_data_q <= load_data_i;
                if (!at_top) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
                if (word_count_q != WC_MAX) begin
                    word_count_q <= word_count_q + (ADDR_W+1)'(1);
                end
                if (at_top && !load_last_i) begin
                    err_overflow_q <= 1'b1;
                end
            end
            // timer counts the HOLD cycles; the exit is taken when it reads 1
            if (enter_hold) begin
                hold_cnt_q <= HOLD_INIT;
            end else if (state_q == S_HOLD) begin
                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end
        end
    end

    assign imem_wr_en_o   = wr_en_q;
    assign imem_wr_addr_o = wr_addr_q;
    assign imem_data_in_o = wr_data_q;
    assign word_count_o   = word_count_q;
    assign err_overflow_o = err_overflow_q;

endmodule
